fill_sequencer: RTL and testbench
=================================

Name: fill_sequencer

Overview:
- Run-time controller for the bottling datapath: sequences pill dispensing into the current bottle via a req/ack handshake with the dispenser, then pulses the conveyor to advance to the next bottle, until the latched bottle target is met.
- Sits between the main state control (start/suspend, targets from the setting logic) and the physical dispenser/conveyor.
- Supplies the bottle and pill counts and status flags that feed the display and state-LED logic.

Parameters:
- CNT_W, 6, width of all count and target values.
- TIMEOUT, 15, cycles allowed between req assertion and ack before a jam is declared; must be ≥2.
- ADV_CYCLES, 3, cycles out_conveyor_en is held high per bottle advance; must be ≥1.

Ports:
- in_clk  input  1  system clock, rising edge.
- in_reset  input  1  asynchronous active-high reset.
- in_start  input  1  one-cycle start/retry strobe.
- in_suspend  input  1  level; freezes progress while high.
- in_target_bottle_num  input  CNT_W  bottles per run.
- in_target_pill_num  input  CNT_W  pills per bottle.
- in_disp_ack  input  1  dispenser acknowledge, four-phase.
- out_disp_req  output  1  dispense request.
- out_conveyor_en  output  1  conveyor drive.
- out_bottle_num  output  CNT_W  completed bottles.
- out_pill_num  output  CNT_W  pills in current bottle.
- out_next_bottle  output  1  one-cycle pulse when a bottle completes.
- out_finish  output  1  run complete, level.
- out_jam  output  1  jam detected, level.
- out_cfg_err  output  1  one-cycle pulse on start with a zero target.
- out_state  output  3  current state encoding.

Behaviour:
- Reset value of all outputs and internal registers is 0; state IDLE. Reset mid-operation aborts the run immediately, with no handshake completion.
- State encoding: IDLE=0, DISPENSE=1, RELEASE=2, ADVANCE=3, DONE=4, JAM=5. Codes 6 and 7 return to IDLE on the next clock.
- IDLE / DONE, on in_start:
  - Either target 0: out_cfg_err pulses for the next cycle; state unchanged.
  - Otherwise: latch both targets, clear both counts, clear the timeout counter, go to DISPENSE. out_disp_req is high in the cycle after the start strobe if in_suspend is low.
- Latched targets are immune to input changes until the next accepted start.
- DISPENSE:
  - out_disp_req = 1 while in_suspend is low; it is combinationally 0 while in_suspend is high.
  - Dispenser contract: req may be withdrawn before ack is given.
  - ack is honoured only in a cycle where req=1. On honoured ack: pill_num+1, go to RELEASE.
  - The timeout counter increments on each cycle with req=1 and ack=0. It holds while suspended. When the count reaches TIMEOUT: go to JAM, out_jam=1.
- RELEASE:
  - req=0; in_suspend is ignored.
  - Wait for ack=0. Then, if pill_num == target_pill go to ADVANCE with the advance counter cleared; otherwise go to DISPENSE with the timeout counter cleared.
- ADVANCE:
  - out_conveyor_en = 1 while in_suspend is low; the cycle counter increments only then.
  - On the ADV_CYCLES-th enabled cycle: bottle_num+1, pill_num<=0, out_next_bottle pulses for one cycle (registered, coincident with the count update).
  - Then, if the new bottle_num == target_bottle go to DONE; otherwise go to DISPENSE.
- DONE: out_finish=1; counts hold for display; in_start behaves as in IDLE.
- JAM:
  - out_jam=1; req and conveyor are 0; counts hold.
  - in_start (targets are not re-latched, no zero check) clears out_jam and the timeout counter and re-enters DISPENSE. The current pill count is preserved, so no pill is double-counted.
- in_start in DISPENSE, RELEASE or ADVANCE is ignored.
- Count arithmetic is modulo 2^CNT_W. Wrap cannot occur because counts stop at the latched target (max 2^CNT_W−1).
- Simultaneous events:
  - ack together with the timeout threshold in the same cycle: ack wins, no jam.
  - in_suspend rising in the same cycle as an honoured ack: req was 0 that cycle, so the ack is not honoured.

Test Plan:
- Targets 2 bottles × 3 pills, ack returns 2 cycles after each req and drops 1 cycle after req falls → exactly 6 honoured acks; out_next_bottle pulses twice; conveyor high 3 cycles per bottle; out_finish=1 with bottle_num=2, pill_num=0.
- Start with target_pill=0 → out_cfg_err pulses once, state stays 0, req never asserts; repeat with target_bottle=0 → same result.
- Hold ack low with TIMEOUT=15 → out_jam rises after exactly 15 req-high cycles, req drops; in_start → jam clears, req reasserts, pill_num unchanged.
- Raise in_suspend for 10 cycles mid-DISPENSE and mid-ADVANCE → req/conveyor low, timeout and advance counters frozen; completion delayed by exactly 10 cycles per suspension; counts unchanged; no jam.
- Change both targets to 9 mid-run → run still completes at the originally latched 2×3.
- Assert in_reset during RELEASE with ack high → all outputs 0 immediately; a new start after reset completes a full run normally.

Source files
------------

// File: rtl/fill_sequencer.sv
// fill_sequencer: run-time controller for the bottling line.
// Drives the dispenser through a four-phase req/ack handshake, counts pills
// into the current bottle, pulses the conveyor to index to the next bottle
// and stops once the latched bottle target is reached. A dispenser that
// never acknowledges is reported as a jam and can be retried with in_start.
module fill_sequencer #(
    parameter int CNT_W      = 6,
    parameter int TIMEOUT    = 15,
    parameter int ADV_CYCLES = 3
) (
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic             in_start,
    input  logic             in_suspend,
    input  logic [CNT_W-1:0] in_target_bottle_num,
    input  logic [CNT_W-1:0] in_target_pill_num,
    input  logic             in_disp_ack,
    output logic             out_disp_req,
    output logic             out_conveyor_en,
    output logic [CNT_W-1:0] out_bottle_num,
    output logic [CNT_W-1:0] out_pill_num,
    output logic             out_next_bottle,
    output logic             out_finish,
    output logic             out_jam,
    output logic             out_cfg_err,
    output logic [2:0]       out_state
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int ADV_W = $clog2(ADV_CYCLES + 1);

    // Last count value before the threshold: the cycle in which the timeout
    // counter holds this value and req is still unanswered is the final one.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADV_W-1:0] ADV_LAST = ADV_W'(ADV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DISPENSE = 3'd1,
        S_RELEASE  = 3'd2,
        S_ADVANCE  = 3'd3,
        S_DONE     = 3'd4,
        S_JAM      = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_tgt_bottle;
    logic [CNT_W-1:0] r_tgt_pill;
    logic [CNT_W-1:0] r_bottle_num;
    logic [CNT_W-1:0] r_pill_num;
    logic [TMO_W-1:0] r_tmo;
    logic [ADV_W-1:0] r_adv;
    logic             r_next_bottle;
    logic             r_cfg_err;

    logic             w_req;
    logic             w_conv;
    logic             w_tgt_zero;
    logic [CNT_W-1:0] w_bottle_inc;

    // Request and conveyor drop combinationally with suspend so the
    // dispenser and motor stop in the same cycle suspend is raised.
    always_comb begin
        w_req        = (r_state == S_DISPENSE) && !in_suspend;
        w_conv       = (r_state == S_ADVANCE) && !in_suspend;
        w_tgt_zero   = (in_target_bottle_num == '0) || (in_target_pill_num == '0);
        w_bottle_inc = r_bottle_num + CNT_ONE;
    end

    // Sequencer state, counters and registered status pulses.
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            r_state       <= S_IDLE;
            r_tgt_bottle  <= '0;
            r_tgt_pill    <= '0;
            r_bottle_num  <= '0;
            r_pill_num    <= '0;
            r_tmo         <= '0;
            r_adv         <= '0;
            r_next_bottle <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_next_bottle <= 1'b0;
            r_cfg_err     <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (in_start) begin
                        if (w_tgt_zero) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_tgt_bottle <= in_target_bottle_num;
                            r_tgt_pill   <= in_target_pill_num;
                            r_bottle_num <= '0;
                            r_pill_num   <= '0;
                            r_tmo        <= '0;
                            r_state      <= S_DISPENSE;
                        end
                    end
                end
                S_DISPENSE: begin
                    // An ack only counts while req is actually presented;
                    // an ack on the threshold cycle beats the jam.
                    if (w_req) begin
                        if (in_disp_ack) begin
                            r_pill_num <= r_pill_num + CNT_ONE;
                            r_state    <= S_RELEASE;
                        end else if (r_tmo == TMO_LAST) begin
                            r_tmo   <= r_tmo + 1'b1;
                            r_state <= S_JAM;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (!in_disp_ack) begin
                        if (r_pill_num == r_tgt_pill) begin
                            r_adv   <= '0;
                            r_state <= S_ADVANCE;
                        end else begin
                            r_tmo   <= '0;
                            r_state <= S_DISPENSE;
                        end
                    end
                end
                S_ADVANCE: begin
                    if (!in_suspend) begin
                        if (r_adv == ADV_LAST) begin
                            r_bottle_num  <= w_bottle_inc;
                            r_pill_num    <= '0;
                            r_next_bottle <= 1'b1;
                            r_tmo         <= '0;
                            r_state       <= (w_bottle_inc == r_tgt_bottle) ? S_DONE : S_DISPENSE;
                        end else begin
                            r_adv <= r_adv + 1'b1;
                        end
                    end
                end
                S_JAM: begin
                    // Retry keeps the pill count: the unanswered request
                    // never delivered a pill.
                    if (in_start) begin
                        r_tmo   <= '0;
                        r_state <= S_DISPENSE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_disp_req    = w_req;
    assign out_conveyor_en = w_conv;
    assign out_bottle_num  = r_bottle_num;
    assign out_pill_num    = r_pill_num;
    assign out_next_bottle = r_next_bottle;
    assign out_finish      = (r_state == S_DONE);
    assign out_jam         = (r_state == S_JAM);
    assign out_cfg_err     = r_cfg_err;
    assign out_state       = r_state;

endmodule

// File: tb/tb_fill_sequencer.sv
// Directed bench for fill_sequencer with hand-computed expectations.
module tb_fill_sequencer;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             suspend = 1'b0;
    logic [CNT_W-1:0] tgt_b = '0;
    logic [CNT_W-1:0] tgt_p = '0;
    logic             ack = 1'b0;
    logic             req;
    logic             conv;
    logic [CNT_W-1:0] bottle;
    logic [CNT_W-1:0] pill;
    logic             nb;
    logic             finish;
    logic             jam;
    logic             cfg_err;
    logic [2:0]       state;

    int n_vec = 0;
    int n_err = 0;
    int hon_acks = 0;
    int nb_pulses = 0;

    fill_sequencer #(.CNT_W(CNT_W), .TIMEOUT(15), .ADV_CYCLES(3)) dut (
        .in_clk               (clk),
        .in_reset             (rst),
        .in_start             (start),
        .in_suspend           (suspend),
        .in_target_bottle_num (tgt_b),
        .in_target_pill_num   (tgt_p),
        .in_disp_ack          (ack),
        .out_disp_req         (req),
        .out_conveyor_en      (conv),
        .out_bottle_num       (bottle),
        .out_pill_num         (pill),
        .out_next_bottle      (nb),
        .out_finish           (finish),
        .out_jam              (jam),
        .out_cfg_err          (cfg_err),
        .out_state            (state)
    );

    always #5 clk = ~clk;

    // Event counters for handshake and bottle-complete pulses.
    always @(posedge clk) begin
        if (req && ack) hon_acks <= hon_acks + 1;
        if (nb) nb_pulses <= nb_pulses + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One dispense: ack two cycles after req, dropped one cycle into RELEASE.
    task automatic serve_pill(input int pill_after);
        chk("req_on", req, 1);
        step();
        step();
        ack = 1'b1;
        step();
        chk("rel_state", state, 2);
        chk("rel_pill", pill, pill_after);
        chk("rel_req", req, 0);
        step();
        ack = 1'b0;
        step();
    endtask

    // Three conveyor cycles, then the bottle-complete update.
    task automatic advance(input int b_after, input int st_after);
        chk("adv_conv1", conv, 1);
        step();
        chk("adv_conv2", conv, 1);
        step();
        chk("adv_conv3", conv, 1);
        step();
        chk("adv_conv_off", conv, 0);
        chk("adv_nb", nb, 1);
        chk("adv_bottle", bottle, b_after);
        chk("adv_pill", pill, 0);
        chk("adv_state", state, st_after);
    endtask

    initial begin
        // Reset state
        tgt_b = 6'd2;
        tgt_p = 6'd3;
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_req", req, 0);
        chk("rst_conv", conv, 0);
        chk("rst_bottle", bottle, 0);
        chk("rst_pill", pill, 0);
        chk("rst_flags", {nb, finish, jam, cfg_err}, 0);
        rst = 1'b0;
        step();
        chk("idle_state", state, 0);

        // Full run 2 x 3, targets changed to 9 mid-run
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_state", state, 1);
        chk("run_req", req, 1);
        serve_pill(1);
        chk("run_disp", state, 1);
        tgt_b = 6'd9;
        tgt_p = 6'd9;
        serve_pill(2);
        serve_pill(3);
        chk("run_to_adv", state, 3);
        advance(1, 1);
        serve_pill(1);
        serve_pill(2);
        serve_pill(3);
        advance(2, 4);
        step();
        chk("run_nb_off", nb, 0);
        chk("run_finish", finish, 1);
        chk("run_bottle", bottle, 2);
        chk("run_acks", hon_acks, 6);
        chk("run_pulses", nb_pulses, 2);

        // Zero targets from DONE
        tgt_p = 6'd0;
        tgt_b = 6'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("cfg_p_err", cfg_err, 1);
        chk("cfg_p_state", state, 4);
        chk("cfg_p_req", req, 0);
        step();
        chk("cfg_p_pulse", cfg_err, 0);
        tgt_p = 6'd3;
        tgt_b = 6'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("cfg_b_err", cfg_err, 1);
        chk("cfg_b_state", state, 4);
        step();
        chk("cfg_b_pulse", cfg_err, 0);
        chk("cfg_b_bottle", bottle, 2);

        // Jam after 15 unanswered req cycles, then retry
        tgt_b = 6'd1;
        tgt_p = 6'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("jam_start", state, 1);
        chk("jam_counts", {bottle, pill}, 0);
        serve_pill(1);
        for (int i = 0; i < 14; i++) begin
            step();
            chk("jam_wait", state, 1);
        end
        step();
        chk("jam_state", state, 5);
        chk("jam_flag", jam, 1);
        chk("jam_req", req, 0);
        chk("jam_pill", pill, 1);
        step();
        step();
        chk("jam_hold", jam, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("retry_jam", jam, 0);
        chk("retry_state", state, 1);
        chk("retry_req", req, 1);
        chk("retry_pill", pill, 1);
        for (int i = 0; i < 14; i++) step();
        ack = 1'b1;
        step();
        chk("tie_state", state, 2);
        chk("tie_jam", jam, 0);
        chk("tie_pill", pill, 2);
        step();
        ack = 1'b0;
        step();
        chk("tie_adv", state, 3);
        advance(1, 4);

        // Suspend mid-DISPENSE and mid-ADVANCE, 10 cycles each
        tgt_b = 6'd1;
        tgt_p = 6'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        suspend = 1'b1;
        #1;
        chk("sus_req", req, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("sus_disp", {state, req}, {3'd1, 1'b0});
        end
        ack = 1'b1;
        step();
        chk("sus_ack_ign", state, 1);
        chk("sus_ack_pill", pill, 0);
        ack = 1'b0;
        suspend = 1'b0;
        #1;
        chk("sus_req_back", req, 1);
        for (int i = 0; i < 11; i++) begin
            step();
            chk("sus_nojam", state, 1);
        end
        ack = 1'b1;
        step();
        chk("sus_rel", state, 2);
        chk("sus_pill", pill, 1);
        step();
        ack = 1'b0;
        step();
        chk("sus_adv", conv, 1);
        step();
        suspend = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("sus_conv", {state, conv}, {3'd3, 1'b0});
            step();
        end
        suspend = 1'b0;
        #1;
        chk("sus_conv_back", conv, 1);
        step();
        chk("sus_conv_last", conv, 1);
        step();
        chk("sus_done", state, 4);
        chk("sus_bottle", bottle, 1);
        chk("sus_nb", nb, 1);

        // Reset during RELEASE with ack high, then a fresh run
        start = 1'b1;
        step();
        start = 1'b0;
        ack = 1'b1;
        step();
        chk("mid_rel", state, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_out", {req, conv, nb, finish, jam, cfg_err}, 0);
        chk("mid_rst_cnt", {bottle, pill}, 0);
        ack = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", state, 0);
        tgt_p = 6'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("idle_cfg_err", cfg_err, 1);
        chk("idle_cfg_state", {state, req}, 0);
        tgt_p = 6'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        serve_pill(1);
        serve_pill(2);
        chk("fresh_adv", state, 3);
        advance(1, 4);
        step();
        chk("fresh_finish", finish, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
